// File: rtl/branch_recovery_ctrl_if.sv
// ---------------------------------------------------------------------------
// branch_recovery_ctrl_if
//
// Groups every non-clock/reset signal of the branch recovery controller.
//
//   Branch FU side : b_done, b_mispredict, b_hit, b_tag, b_target
//   ROB side       : rob_head, rob_tail (pointers)
//                    walk_idx (lookup index, driven by the controller)
//                    walk_has_dest, walk_rd, walk_pd, walk_old_pd
//                    (ROB fields at walk_idx, returned in the same cycle)
//                    tail_restore_valid, tail_restore
//   Fetch side     : redirect_valid, redirect_pc, flush, busy
//   Rename side    : rat_restore_valid/_rd/_pd, free_valid, free_pd
//   Perf counters  : mispredict_count, hit_count
//
// Modports:
//   master - the recovery controller itself
//   slave  - the surrounding pipeline (branch FU, ROB, RAT, fetch)
// ---------------------------------------------------------------------------
interface branch_recovery_ctrl_if #(
    parameter int TAG_W  = 5,
    parameter int PREG_W = 7
);
    // branch functional unit
    logic              b_done;
    logic              b_mispredict;
    logic              b_hit;
    logic [TAG_W-1:0]  b_tag;
    logic [31:0]       b_target;

    // ROB pointers and walk lookup
    logic [TAG_W-1:0]  rob_head;
    logic [TAG_W-1:0]  rob_tail;
    logic [TAG_W-1:0]  walk_idx;
    logic              walk_has_dest;
    logic [4:0]        walk_rd;
    logic [PREG_W-1:0] walk_pd;
    logic [PREG_W-1:0] walk_old_pd;

    // fetch / front end
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              flush;
    logic              busy;

    // rename map and free list
    logic              rat_restore_valid;
    logic [4:0]        rat_restore_rd;
    logic [PREG_W-1:0] rat_restore_pd;
    logic              free_valid;
    logic [PREG_W-1:0] free_pd;

    // ROB tail truncation
    logic              tail_restore_valid;
    logic [TAG_W-1:0]  tail_restore;

    // performance counters
    logic [31:0]       mispredict_count;
    logic [31:0]       hit_count;

    modport master (
        input  b_done, b_mispredict, b_hit, b_tag, b_target,
        input  rob_head, rob_tail,
        input  walk_has_dest, walk_rd, walk_pd, walk_old_pd,
        output walk_idx,
        output redirect_valid, redirect_pc, flush, busy,
        output rat_restore_valid, rat_restore_rd, rat_restore_pd,
        output free_valid, free_pd,
        output tail_restore_valid, tail_restore,
        output mispredict_count, hit_count
    );

    modport slave (
        output b_done, b_mispredict, b_hit, b_tag, b_target,
        output rob_head, rob_tail,
        output walk_has_dest, walk_rd, walk_pd, walk_old_pd,
        input  walk_idx,
        input  redirect_valid, redirect_pc, flush, busy,
        input  rat_restore_valid, rat_restore_rd, rat_restore_pd,
        input  free_valid, free_pd,
        input  tail_restore_valid, tail_restore,
        input  mispredict_count, hit_count
    );
endinterface

// File: rtl/branch_recovery_ctrl.sv
// ---------------------------------------------------------------------------
// branch_recovery_ctrl
//
// Misprediction recovery for an out-of-order core. On a mispredicted branch
// it redirects fetch and flushes the front end, walks the ROB backward from
// the youngest entry down to the entry just above the branch (one entry per
// cycle) restoring the rename map and freeing the squashed physical
// registers, then truncates the ROB tail to just above the branch.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous, active-low reset
//   brc    - branch_recovery_ctrl_if.master (see interface for signal list)
//
// Every output is registered except the rename/free pass-through, which is
// qualified combinationally from the ROB fields returned for walk_idx.
// ---------------------------------------------------------------------------
module branch_recovery_ctrl #(
    parameter int ROB_DEPTH = 32,
    parameter int PREG_W    = 7
) (
    input  logic                   clk,
    input  logic                   reset,
    branch_recovery_ctrl_if.master brc
);
    localparam int TAG_W = $clog2(ROB_DEPTH);

    typedef logic [TAG_W-1:0]  tag_t;
    typedef logic [PREG_W-1:0] preg_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        WALK     = 2'd2,
        TRUNC    = 2'd3
    } state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t      state_reg,    state_next;
    tag_t        cur_tag_reg,  cur_tag_next;   // branch being recovered
    logic [31:0] cur_pc_reg,   cur_pc_next;    // its corrected target
    tag_t        walk_ptr_reg, walk_ptr_next;  // next ROB entry to undo
    tag_t        head_reg,     head_next;      // ROB head captured at accept

    // registered outputs
    logic        redirect_valid_reg;
    logic [31:0] redirect_pc_reg;
    logic        flush_reg;
    logic        busy_reg;
    logic        walk_valid_reg;
    tag_t        walk_idx_reg;
    logic        tail_restore_valid_reg;
    tag_t        tail_restore_reg;
    logic [31:0] mispredict_count_reg;
    logic [31:0] hit_count_reg;

    logic        mp_event;
    logic        hit_event;
    logic        nested_older;

    assign mp_event  = brc.b_done & brc.b_mispredict;
    assign hit_event = brc.b_done & brc.b_hit;

    // Age relative to the head captured when recovery started. The ROB does
    // not allocate while busy, so that head stays a valid reference point.
    // Unsigned TAG_W subtraction gives the modulo-ROB_DEPTH wrap for free.
    function automatic tag_t age(input tag_t t, input tag_t h);
        return t - h;
    endfunction

    // A mispredict arriving during recovery only matters if it is strictly
    // older than the branch being recovered; anything younger or equal is
    // already in the squashed region.
    assign nested_older = mp_event &&
                          (age(brc.b_tag, head_reg) < age(cur_tag_reg, head_reg));

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        cur_tag_next  = cur_tag_reg;
        cur_pc_next   = cur_pc_reg;
        walk_ptr_next = walk_ptr_reg;
        head_next     = head_reg;

        case (state_reg)
            IDLE: begin
                if (mp_event) begin
                    state_next    = REDIRECT;
                    cur_tag_next  = brc.b_tag;
                    cur_pc_next   = brc.b_target;
                    walk_ptr_next = brc.rob_tail - 1'b1;
                    head_next     = brc.rob_head;
                end
            end
            REDIRECT: begin
                // Branch already youngest -> nothing to undo.
                state_next = (walk_ptr_reg != cur_tag_reg) ? WALK : TRUNC;
            end
            WALK: begin
                walk_ptr_next = walk_ptr_reg - 1'b1;
                if (walk_ptr_reg == cur_tag_reg + 1'b1) begin
                    state_next = TRUNC;
                end
            end
            TRUNC: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // An older mispredict retargets the recovery. walk_ptr is kept (and
        // a WALK step in this cycle still decrements it above), so the walk
        // resumes below what has already been undone and simply continues
        // further down to the new branch.
        if (state_reg != IDLE && nested_older) begin
            state_next   = REDIRECT;
            cur_tag_next = brc.b_tag;
            cur_pc_next  = brc.b_target;
        end
    end

    // -----------------------------------------------------------------------
    // State and output registers. Outputs are decoded from the next state so
    // they line up with the state they describe.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg              <= IDLE;
            cur_tag_reg            <= '0;
            cur_pc_reg             <= '0;
            walk_ptr_reg           <= '0;
            head_reg               <= '0;
            redirect_valid_reg     <= 1'b0;
            redirect_pc_reg        <= '0;
            flush_reg              <= 1'b0;
            busy_reg               <= 1'b0;
            walk_valid_reg         <= 1'b0;
            walk_idx_reg           <= '0;
            tail_restore_valid_reg <= 1'b0;
            tail_restore_reg       <= '0;
            mispredict_count_reg   <= '0;
            hit_count_reg          <= '0;
        end else begin
            state_reg    <= state_next;
            cur_tag_reg  <= cur_tag_next;
            cur_pc_reg   <= cur_pc_next;
            walk_ptr_reg <= walk_ptr_next;
            head_reg     <= head_next;

            redirect_valid_reg     <= (state_next == REDIRECT);
            flush_reg              <= (state_next == REDIRECT);
            busy_reg               <= (state_next != IDLE);
            walk_valid_reg         <= (state_next == WALK);
            tail_restore_valid_reg <= (state_next == TRUNC);

            if (state_next == REDIRECT) begin
                redirect_pc_reg <= cur_pc_next;
            end
            if (state_next == WALK) begin
                walk_idx_reg <= walk_ptr_next;
            end
            if (state_next == TRUNC) begin
                tail_restore_reg <= cur_tag_next + 1'b1;
            end

            // Every reported mispredict counts, including ignored ones.
            if (mp_event) begin
                mispredict_count_reg <= mispredict_count_reg + 32'd1;
            end
            if (hit_event) begin
                hit_count_reg <= hit_count_reg + 32'd1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    preg_t old_pd_w;
    preg_t sq_pd_w;
    logic  restore_w;

    assign old_pd_w  = brc.walk_old_pd;
    assign sq_pd_w   = brc.walk_pd;
    assign restore_w = walk_valid_reg & brc.walk_has_dest;

    assign brc.walk_idx           = walk_idx_reg;
    assign brc.redirect_valid     = redirect_valid_reg;
    assign brc.redirect_pc        = redirect_pc_reg;
    assign brc.flush              = flush_reg;
    assign brc.busy               = busy_reg;
    assign brc.rat_restore_valid  = restore_w;
    assign brc.rat_restore_rd     = brc.walk_rd;
    assign brc.rat_restore_pd     = old_pd_w;
    assign brc.free_valid         = restore_w;
    assign brc.free_pd            = sq_pd_w;
    assign brc.tail_restore_valid = tail_restore_valid_reg;
    assign brc.tail_restore       = tail_restore_reg;
    assign brc.mispredict_count   = mispredict_count_reg;
    assign brc.hit_count          = hit_count_reg;

endmodule

// File: tb/tb_branch_recovery_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_recovery_ctrl
//
// Directed scenarios followed by randomized branch results. Expected behaviour
// comes from a queue of per-cycle actions (redirect / walk entry / truncate)
// rebuilt from the branch tag and ROB pointers whenever a recovery starts or
// is retargeted by an older branch.
// ---------------------------------------------------------------------------
module tb_branch_recovery_ctrl;
    localparam int K_RED   = 1;
    localparam int K_WALK  = 2;
    localparam int K_TRUNC = 3;

    typedef struct {
        int          kind;
        logic [31:0] val;
    } act_t;

    logic clk;
    logic reset;

    branch_recovery_ctrl_if #(.TAG_W(5), .PREG_W(7)) bif ();

    branch_recovery_ctrl #(.ROB_DEPTH(32), .PREG_W(7)) dut (
        .clk   (clk),
        .reset (reset),
        .brc   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROB contents seen through the walk lookup
    logic       rob_has [32];
    logic [4:0] rob_rd  [32];
    logic [6:0] rob_pd  [32];
    logic [6:0] rob_old [32];

    assign bif.walk_has_dest = rob_has[bif.walk_idx];
    assign bif.walk_rd       = rob_rd[bif.walk_idx];
    assign bif.walk_pd       = rob_pd[bif.walk_idx];
    assign bif.walk_old_pd   = rob_old[bif.walk_idx];

    // reference model state
    act_t        q[$];
    logic [4:0]  m_tag;
    logic [4:0]  m_head;
    logic [4:0]  m_next_undo;
    logic [31:0] m_mp_cnt;
    logic [31:0] m_hit_cnt;

    int n_total;
    int n_bad;
    int busy_cycles;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [4:0] m_age(input logic [4:0] t);
        return t - m_head;
    endfunction

    // Recovery sequence for a branch: redirect, undo every entry from start
    // down to just above the branch, then truncate to branch+1.
    task automatic build(input logic [4:0] tag, input logic [31:0] pc, input logic [4:0] start);
        act_t       a;
        logic [4:0] e;
        q.delete();
        a.kind = K_RED; a.val = pc; q.push_back(a);
        e = start;
        m_next_undo = start;
        while (e != tag) begin
            a.kind = K_WALK; a.val = 32'(e); q.push_back(a);
            e = e - 5'd1;
        end
        a.kind = K_TRUNC; a.val = 32'(5'(tag + 5'd1)); q.push_back(a);
    endtask

    // Apply the inputs sampled at this clock edge.
    task automatic model_edge();
        logic mp;
        act_t c;
        mp = bif.b_done && bif.b_mispredict;
        if (bif.b_done && bif.b_hit) m_hit_cnt++;
        if (mp) m_mp_cnt++;
        if (q.size() == 0) begin
            if (mp) begin
                m_head = bif.rob_head;
                m_tag  = bif.b_tag;
                build(bif.b_tag, bif.b_target, bif.rob_tail - 5'd1);
            end
        end else begin
            c = q.pop_front();
            if (c.kind == K_WALK) m_next_undo = c.val[4:0] - 5'd1;
            if (mp && (m_age(bif.b_tag) < m_age(m_tag))) begin
                m_tag = bif.b_tag;
                build(bif.b_tag, bif.b_target, m_next_undo);
            end
        end
    endtask

    task automatic compare();
        act_t a;
        logic has;
        logic is_red, is_walk, is_trunc, restore;
        has = (q.size() != 0);
        a.kind = 0; a.val = '0;
        if (has) a = q[0];
        is_red   = has && a.kind == K_RED;
        is_walk  = has && a.kind == K_WALK;
        is_trunc = has && a.kind == K_TRUNC;
        restore  = is_walk && rob_has[a.val[4:0]];
        chk("busy", 32'(bif.busy), 32'(has));
        chk("redirect_valid", 32'(bif.redirect_valid), 32'(is_red));
        chk("flush", 32'(bif.flush), 32'(is_red));
        if (is_red) chk("redirect_pc", bif.redirect_pc, a.val);
        chk("rat_restore_valid", 32'(bif.rat_restore_valid), 32'(restore));
        chk("free_valid", 32'(bif.free_valid), 32'(restore));
        if (is_walk) chk("walk_idx", 32'(bif.walk_idx), a.val);
        if (restore) begin
            chk("rat_restore_rd", 32'(bif.rat_restore_rd), 32'(rob_rd[a.val[4:0]]));
            chk("rat_restore_pd", 32'(bif.rat_restore_pd), 32'(rob_old[a.val[4:0]]));
            chk("free_pd", 32'(bif.free_pd), 32'(rob_pd[a.val[4:0]]));
        end
        chk("tail_restore_valid", 32'(bif.tail_restore_valid), 32'(is_trunc));
        if (is_trunc) chk("tail_restore", 32'(bif.tail_restore), a.val);
        chk("mispredict_count", bif.mispredict_count, m_mp_cnt);
        chk("hit_count", bif.hit_count, m_hit_cnt);
    endtask

    task automatic step(input logic d, input logic mp, input logic ht,
                        input logic [4:0] tg, input logic [31:0] pc);
        bif.b_done       = d;
        bif.b_mispredict = mp;
        bif.b_hit        = ht;
        bif.b_tag        = tg;
        bif.b_target     = pc;
        @(posedge clk);
        model_edge();
        #1;
        bif.b_done = 1'b0;
        compare();
        if (bif.busy) busy_cycles++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic mispredict(input logic [4:0] tg, input logic [31:0] pc);
        step(1'b1, 1'b1, 1'b0, tg, pc);
    endtask

    task automatic fill_rob();
        for (int i = 0; i < 32; i++) begin
            rob_has[i] = 1'($urandom_range(0, 1));
            rob_rd[i]  = 5'($urandom);
            rob_pd[i]  = 7'($urandom);
            rob_old[i] = 7'($urandom);
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        chk({pfx, "_busy"}, 32'(bif.busy), 32'd0);
        chk({pfx, "_redirect_valid"}, 32'(bif.redirect_valid), 32'd0);
        chk({pfx, "_flush"}, 32'(bif.flush), 32'd0);
        chk({pfx, "_rat_restore_valid"}, 32'(bif.rat_restore_valid), 32'd0);
        chk({pfx, "_free_valid"}, 32'(bif.free_valid), 32'd0);
        chk({pfx, "_tail_restore_valid"}, 32'(bif.tail_restore_valid), 32'd0);
        chk({pfx, "_redirect_pc"}, bif.redirect_pc, 32'd0);
        chk({pfx, "_tail_restore"}, 32'(bif.tail_restore), 32'd0);
        chk({pfx, "_walk_idx"}, 32'(bif.walk_idx), 32'd0);
        chk({pfx, "_mispredict_count"}, bif.mispredict_count, 32'd0);
        chk({pfx, "_hit_count"}, bif.hit_count, 32'd0);
    endtask

    initial begin
        n_total = 0; n_bad = 0; busy_cycles = 0;
        m_mp_cnt = '0; m_hit_cnt = '0; m_tag = '0; m_head = '0; m_next_undo = '0;
        reset = 1'b0;
        bif.b_done = 1'b0; bif.b_mispredict = 1'b0; bif.b_hit = 1'b0;
        bif.b_tag = '0; bif.b_target = '0;
        bif.rob_head = '0; bif.rob_tail = '0;
        fill_rob();

        // reset state
        #22;
        check_reset_outputs("reset");
        reset = 1'b1;

        // basic recovery: head 0, tail 8, branch 3 -> walk 7,6,5,4, tail 4
        bif.rob_head = 5'd0; bif.rob_tail = 5'd8;
        rob_has[7] = 1'b1; rob_rd[7] = 5'd5; rob_pd[7] = 7'd40; rob_old[7] = 7'd12;
        rob_has[6] = 1'b0;
        busy_cycles = 0;
        mispredict(5'd3, 32'h100);
        idle(8);
        chk("basic_busy_len", 32'(busy_cycles), 32'd6);

        // branch is youngest: no walk cycles
        bif.rob_tail = 5'd4;
        busy_cycles = 0;
        mispredict(5'd3, 32'h180);
        idle(4);
        chk("youngest_busy_len", 32'(busy_cycles), 32'd2);

        // wrap-around walk: 1, 0, 31
        bif.rob_head = 5'd28; bif.rob_tail = 5'd2;
        mispredict(5'd30, 32'h2000);
        idle(7);

        // older nested mispredict retargets the walk
        bif.rob_head = 5'd0; bif.rob_tail = 5'd16;
        mispredict(5'd10, 32'h200);
        idle(2);
        mispredict(5'd4, 32'h300);
        idle(14);

        // younger nested mispredict is ignored
        mispredict(5'd10, 32'h400);
        idle(2);
        mispredict(5'd12, 32'h500);
        idle(8);

        // reset in the middle of a walk
        mispredict(5'd2, 32'h600);
        idle(3);
        #3 reset = 1'b0;
        #1;
        check_reset_outputs("midwalk_reset");
        q.delete();
        m_mp_cnt = '0; m_hit_cnt = '0;
        @(posedge clk);
        #1 reset = 1'b1;

        // three hits then one mispredict
        bif.rob_head = 5'd0; bif.rob_tail = 5'd8;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 5'd1, 32'd0);
        step(1'b1, 1'b0, 1'b0, 5'd1, 32'd0);
        mispredict(5'd5, 32'h700);
        idle(5);
        chk("hits_hit_count", bif.hit_count, 32'd3);
        chk("hits_mispredict_count", bif.mispredict_count, 32'd1);

        // randomized branch results
        for (int i = 0; i < 1500; i++) begin
            logic [4:0] cnt;
            logic [4:0] tg;
            int         r;
            if (q.size() == 0 && $urandom_range(0, 3) == 0) begin
                bif.rob_head = 5'($urandom);
                bif.rob_tail = bif.rob_head + 5'($urandom_range(1, 31));
                fill_rob();
            end
            cnt = bif.rob_tail - bif.rob_head;
            tg  = bif.rob_head + 5'($urandom_range(0, int'(cnt) - 1));
            r   = $urandom_range(0, 9);
            if (r < 2)      step(1'b1, 1'b1, 1'b0, tg, $urandom);
            else if (r < 4) step(1'b1, 1'b0, 1'b1, tg, $urandom);
            else if (r < 5) step(1'b1, 1'b0, 1'b0, tg, $urandom);
            else            step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), tg, $urandom);
        end
        idle(40);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
